// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - valid/ready byte FIFO built on a 64x8 single-port RAM
//
// Purpose: arbitrates the single RAM port between producer writes and
// read-address issues, and holds one output word in a skid register.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   s_data/s_valid/s_ready producer stream (accepted when s_valid && s_ready)
//   m_data/m_valid/m_ready consumer stream (m_data registered)
//   ram_data/ram_addr/ram_we  drive to the RAM port
//   ram_q                  RAM output for the address latched on the last we=0 edge
//   count                  words held: RAM + in-flight read + output register
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_count;
  logic              pend;
  logic              rd_issue;
  logic              wr_fire;

  // A read is issued only when the output register will be free by the time
  // the RAM data comes back; issuing takes the port, so it blocks writes.
  always_comb begin
    rd_issue = (ram_count != '0) && !pend && (!m_valid || m_ready) && !rst;
    s_ready  = (ram_count < DEPTH_C) && !rd_issue && !rst;
    wr_fire  = s_valid && s_ready;
  end

  // Idle cycles present wr_ptr with we=0; the RAM relatches it harmlessly
  // because no read result is awaited (pend=0) at that point.
  always_comb begin
    ram_we   = wr_fire;
    ram_addr = rd_issue ? rd_ptr : wr_ptr;
    ram_data = s_data;
  end

  assign count = ram_count + {{ADDR_W{1'b0}}, pend} + {{ADDR_W{1'b0}}, m_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      pend      <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;

      // Write and issue never coincide, so at most one adjustment applies.
      if (wr_fire) begin
        ram_count <= ram_count + 1'b1;
      end else if (rd_issue) begin
        ram_count <= ram_count - 1'b1;
      end

      pend <= rd_issue;

      // A capture cycle always has m_valid=0 (the issue a cycle earlier
      // required a free or emptying output), so capture and take never mix.
      if (pend) begin
        m_data  <= ram_q;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - self-checking bench for ram_fifo_ctrl with a behavioural RAM
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] ram_data;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;
  logic [6:0] count;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
    .count(count)
  );

  // 64x8 single-port RAM: registered read address latched only when we=0.
  logic [7:0] mem [0:63];
  logic [5:0] addr_q;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    addr_q = 6'd0;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    else        addr_q <= ram_addr;
  end
  assign ram_q = mem[addr_q];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of accepted bytes, plus a count of writes
  // to predict the RAM write address.
  logic [7:0] q[$];
  bit         chk_en = 0;
  int         wr_model = 0;
  int         n_out = 0;
  bit         prev_hold = 0;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    if (chk_en) begin
      check("mon_count", count, q.size());
      check("mon_we_handshake", ram_we, s_valid && s_ready);
      if (ram_we) begin
        check("mon_wr_addr", ram_addr, wr_model % 64);
        wr_model++;
      end
      if (prev_hold) begin
        check("mon_hold_valid", m_valid, 1);
        check("mon_hold_data", m_data, prev_data);
      end
      if (s_valid && s_ready) q.push_back(s_data);
      if (m_valid && m_ready) begin
        if (q.size() == 0) check("mon_underflow", q.size(), 1);
        else begin
          check("mon_order", m_data, q.pop_front());
          n_out++;
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end else begin
      prev_hold = 0;
    end
  end

  typedef struct {
    logic       rst;
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       e_sr;
    logic       e_we;
    logic [5:0] e_addr;
    logic       e_mv;
    logic [7:0] e_md;
    logic [6:0] e_cnt;
  } vec_t;

  vec_t vt [7];

  task automatic step_in(input logic r, input logic sv, input logic [7:0] sd, input logic mr);
    @(posedge clk); #1;
    rst = r; s_valid = sv; s_data = sd; m_ready = mr;
    @(negedge clk);
  endtask

  initial begin
    int k;
    int cyc;
    int last_take;
    int nxt;

    // Reset twice with s_valid high, then one byte 0xA5 through an empty FIFO.
    vt[0] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 7'd0};
    vt[1] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 7'd0};
    vt[2] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 6'd0, 1'b0, 8'h00, 7'd0};
    vt[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 7'd1};
    vt[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd1, 1'b0, 8'h00, 7'd1};
    vt[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd1, 1'b1, 8'hA5, 7'd1};
    vt[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd1, 1'b0, 8'hA5, 7'd0};

    rst = 1'b1; s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      step_in(vt[i].rst, vt[i].sv, vt[i].sd, vt[i].mr);
      check($sformatf("vec%0d_s_ready", i), s_ready, vt[i].e_sr);
      check($sformatf("vec%0d_ram_we", i), ram_we, vt[i].e_we);
      check($sformatf("vec%0d_ram_addr", i), ram_addr, vt[i].e_addr);
      check($sformatf("vec%0d_m_valid", i), m_valid, vt[i].e_mv);
      check($sformatf("vec%0d_m_data", i), m_data, vt[i].e_md);
      check($sformatf("vec%0d_count", i), count, vt[i].e_cnt);
    end

    // Fill: consumer stalled, 0x00.. offered continuously; 65 must be accepted.
    step_in(1'b1, 1'b0, 8'h00, 1'b0);
    k = 0;
    for (int c = 0; c < 150; c++) begin
      step_in(1'b0, (k < 8'h46), k[7:0], 1'b0);
      if (s_valid && s_ready) k++;
    end
    check("fill_accepted", k, 65);
    check("fill_count", count, 65);
    check("fill_s_ready", s_ready, 0);
    check("fill_m_valid", m_valid, 1);
    check("fill_m_data", m_data, 8'h00);

    // Drain: in order, one word every two cycles.
    k = 0; last_take = -1;
    for (int c = 0; c < 300 && k < 65; c++) begin
      step_in(1'b0, 1'b0, 8'h00, 1'b1);
      if (m_valid) begin
        check("drain_count", count, 65 - k);
        check("drain_data", m_data, k);
        if (last_take >= 0) check("drain_gap", c - last_take, 2);
        last_take = c;
        k++;
      end
    end
    check("drain_taken", k, 65);
    step_in(1'b0, 1'b0, 8'h00, 1'b1);
    check("drain_m_valid_low", m_valid, 0);
    check("drain_count_zero", count, 0);

    // Random concurrency: 200 incrementing bytes against the model.
    step_in(1'b1, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); wr_model = 0; n_out = 0;
    @(negedge clk);
    chk_en = 1;
    nxt = 0; cyc = 0;
    while (nxt < 200 && cyc < 5000) begin
      @(posedge clk); #1;
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = nxt[7:0];
      m_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (s_valid && s_ready) nxt++;
      cyc++;
    end
    check("rand_all_sent", nxt, 200);
    for (int c = 0; c < 200; c++) step_in(1'b0, 1'b0, 8'h00, 1'b1);
    check("rand_all_out", n_out, 200);
    check("rand_model_empty", q.size(), 0);
    check("rand_count_zero", count, 0);
    chk_en = 0;

    // Reset mid-stream with count=10 and a read in flight.
    k = 0;
    for (int c = 0; c < 100 && k < 11; c++) begin
      step_in(1'b0, 1'b1, 8'h10 + k[7:0], 1'b0);
      if (s_ready) k++;
    end
    for (int c = 0; c < 4; c++) step_in(1'b0, 1'b0, 8'h00, 1'b0);
    check("mid_count_11", count, 11);
    step_in(1'b0, 1'b0, 8'h00, 1'b1);
    check("mid_take_data", m_data, 8'h10);
    step_in(1'b1, 1'b0, 8'h00, 1'b0);
    check("mid_count_10", count, 10);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_ram_we", ram_we, 0);
    step_in(1'b0, 1'b1, 8'h5A, 1'b1);
    check("mid_after_count", count, 0);
    check("mid_after_m_valid", m_valid, 0);
    check("mid_after_m_data", m_data, 8'h00);
    check("mid_write_accept", s_ready, 1);
    k = 0;
    for (int c = 0; c < 20 && !m_valid; c++) begin
      step_in(1'b0, 1'b0, 8'h00, 1'b1);
      k++;
    end
    check("mid_latency", k, 3);
    check("mid_first_out", m_data, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- FIFO controller that turns the team's 64x8 single-port RAM (registered read address, write-first port) into a valid/ready byte stream buffer.
- Sits between a byte producer and a byte consumer, directly driving the RAM's data/addr/we pins and consuming its q output.
- Arbitrates the single RAM port between writes and read-address issues; holds one output byte in a skid register.

Parameters:
- DATA_W, 8, width of stored words; must match RAM data width.
- ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W (64) is a derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_W  producer write data.
- s_valid  in  1  producer has data.
- s_ready  out  1  controller accepts s_data this cycle.
- m_data  out  DATA_W  consumer read data (registered).
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer takes m_data this cycle.
- ram_data  out  DATA_W  to RAM data.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_we  out  1  to RAM we.
- ram_q  in  DATA_W  from RAM q; reflects the address latched on the last we=0 edge.
- count  out  ADDR_W+1  total held words: ram_count + pend + m_valid (0..DEPTH+1).

Behaviour:
- The controller has one clock (clk) and one reset (rst). rst is synchronous and active-high, sampled on the rising edge of clk.
- State: wr_ptr, rd_ptr (ADDR_W, wrap modulo DEPTH); ram_count (ADDR_W+1, 0..DEPTH); pend (1 bit, read in flight); m_valid/m_data output register.
- Reset values: wr_ptr=rd_ptr=0, ram_count=0, pend=0, m_valid=0, m_data=0. During reset cycles s_ready=0 and ram_we=0. Reset mid-stream discards all contents, including in-flight reads.
- rd_issue (combinational) = ram_count!=0 && !pend && (!m_valid || m_ready) && !rst.
- s_ready (combinational) = ram_count<DEPTH && !rd_issue && !rst. Read issue has priority over write on the shared port.
- wr_fire = s_valid && s_ready.
- RAM drive: ram_we=wr_fire; ram_addr = rd_issue ? rd_ptr : wr_ptr; ram_data=s_data (don't-care when ram_we=0).
- Idle cycles (no issue, no write): ram_addr=wr_ptr, we=0. This harmlessly relatches the RAM address because pend=0.
- On wr_fire: wr_ptr+1, ram_count+1.
- On rd_issue: rd_ptr+1, ram_count-1, pend<=1.
- Same-cycle write and issue are impossible by construction.
- When pend=1 (cycle after issue): ram_q is valid. At the edge, m_data<=ram_q, m_valid<=1, pend<=0. A write may occur in the pend cycle, since we=1 does not disturb the RAM's latched address.
- Consumer handshake: m_valid && m_ready with no capture in that edge clears m_valid. Capture and take in the same cycle is impossible (rd_issue requires pend=0), so capture always sets m_valid=1.
- m_data/m_valid are stable while m_valid && !m_ready.
- Latency: byte accepted in cycle W appears as m_valid in cycle W+3 when the FIFO is otherwise empty.
- Steady-state throughput is 1 word per 2 cycles on each side.
- Full: ram_count=DEPTH forces s_ready=0. Total capacity is DEPTH+1 (64 in RAM plus 1 in m_data).
- Empty: ram_count=0 means no issue; m_valid drops after the last take.
- Pointer wrap from 63 to 0 is seamless; ordering is strict FIFO.

Test Plan:
- Reset: hold rst 2 cycles with s_valid=1 -> s_ready=0, ram_we=0, m_valid=0, m_data=0, count=0.
- Single byte: write 0xA5 at cycle W, m_ready=1 -> ram_we=1, ram_addr=0 at W; ram_addr=0, we=0 at W+1; m_valid=1, m_data=0xA5 at W+3; count returns 0 after take.
- Fill: m_ready=0, drive 0x00..0x45 continuously -> exactly 65 accepted (0x00 lands in m_data, 0x01..0x40 in RAM); s_ready=0 at count=65; m_data stays 0x00.
- Drain after fill: m_ready=1 -> m_data sequence 0x00..0x40 in order with one-cycle gaps; count decrements to 0; m_valid low afterwards.
- Wrap and concurrency: stream 200 incrementing bytes with random s_valid/m_ready -> output matches input order exactly, wr_ptr/rd_ptr wrap past 63, never ram_we=1 in an rd_issue cycle.
- Reset mid-operation: assert rst with count=10 and pend=1 -> next cycle count=0, m_valid=0; the following write of 0x5A emerges first.
